// File: rtl/tank_game_pkg.sv
// Shared state type, default tuning values and a small hp helper for the
// two-tank artillery turn sequencer.
package tank_game_pkg;

  localparam int HP_INIT_DEFAULT        = 5;
  localparam int CHARGE_STEP_DEFAULT    = 10;
  localparam int CHARGE_MAX_DEFAULT     = 600;
  localparam int FLIGHT_TIMEOUT_DEFAULT = 255;
  localparam int SETTLE_FRAMES_DEFAULT  = 30;

  localparam int HP_W     = 3;
  localparam int CHARGE_W = 10;

  typedef enum logic [2:0] {
    ARM,
    AIM,
    CHARGE,
    FIRE,
    FLIGHT,
    RESOLVE,
    SETTLE,
    OVER
  } turn_state_t;

  // Hit points after an optional hit; never goes below zero.
  function automatic logic [HP_W-1:0] hpAfterHit(input logic [HP_W-1:0] hp, input logic hit);
    return (hit && (hp != '0)) ? (hp - HP_W'(1)) : hp;
  endfunction

endpackage

// File: rtl/turn_sequencer_if.sv
// Player / bullet-datapath side of the turn sequencer. The master side
// (game logic, buttons, bullet engine) drives buttons and bullet pulses;
// the slave side (the sequencer) drives turn, launch and score outputs.
interface turn_sequencer_if;
  import tank_game_pkg::*;

  logic                fire_a;
  logic                fire_b;
  logic                bullet_hit;
  logic                bullet_done;
  logic [1:0]          currentTank;
  logic                shoot;
  logic [CHARGE_W-1:0] y_component;
  logic [HP_W-1:0]     hp_a;
  logic [HP_W-1:0]     hp_b;
  logic                game_over;
  logic                winner;

  modport master (
    output fire_a, fire_b, bullet_hit, bullet_done,
    input  currentTank, shoot, y_component, hp_a, hp_b, game_over, winner
  );

  modport slave (
    input  fire_a, fire_b, bullet_hit, bullet_done,
    output currentTank, shoot, y_component, hp_a, hp_b, game_over, winner
  );

endinterface

// File: rtl/charge_meter.sv
// Saturating launch-charge accumulator. The saturation test is done before
// the add so the 10-bit sum can never wrap past the maximum.
module charge_meter
  import tank_game_pkg::*;
#(
  parameter int STEP = CHARGE_STEP_DEFAULT,
  parameter int MAX  = CHARGE_MAX_DEFAULT
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                en,
  output logic [CHARGE_W-1:0] value,
  output logic                at_max
);

  localparam logic [CHARGE_W-1:0] STEP_V = CHARGE_W'(STEP);
  localparam logic [CHARGE_W-1:0] MAX_V  = CHARGE_W'(MAX);

  logic [CHARGE_W-1:0] r_value;

  // Clear wins over accumulate; once close to the top, clamp to the maximum.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_value <= '0;
    end else if (en) begin
      if (r_value >= (MAX_V - STEP_V)) begin
        r_value <= MAX_V;
      end else begin
        r_value <= r_value + STEP_V;
      end
    end
  end

  assign value  = r_value;
  assign at_max = (r_value == MAX_V);

endmodule

// File: rtl/turn_sequencer.sv
// Turn sequencer for a two-tank artillery game: arms the active player's
// button, accumulates launch charge, fires once, waits for the bullet
// outcome, scores hits, pauses, then hands the turn to the other tank.
module turn_sequencer
  import tank_game_pkg::*;
#(
  parameter int HP_INIT        = HP_INIT_DEFAULT,
  parameter int CHARGE_STEP    = CHARGE_STEP_DEFAULT,
  parameter int CHARGE_MAX     = CHARGE_MAX_DEFAULT,
  parameter int FLIGHT_TIMEOUT = FLIGHT_TIMEOUT_DEFAULT,
  parameter int SETTLE_FRAMES  = SETTLE_FRAMES_DEFAULT
) (
  input logic             frame_clk,
  input logic             Reset,
  turn_sequencer_if.slave bus
);

  localparam int FLIGHT_W = $clog2(FLIGHT_TIMEOUT + 1);
  localparam int SETTLE_W = $clog2(SETTLE_FRAMES + 1);
  localparam logic [FLIGHT_W-1:0] FLIGHT_LAST = FLIGHT_W'(FLIGHT_TIMEOUT - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_FRAMES - 1);

  turn_state_t         r_state;
  logic                r_tank;
  logic                r_shoot;
  logic                r_hit;
  logic                r_gameOver;
  logic                r_winner;
  logic [HP_W-1:0]     r_hpA;
  logic [HP_W-1:0]     r_hpB;
  logic [FLIGHT_W-1:0] r_flight;
  logic [SETTLE_W-1:0] r_settle;

  logic                w_fireActive;
  logic                w_meterClr;
  logic                w_meterEn;
  logic                w_atMax;
  logic [CHARGE_W-1:0] w_charge;
  logic [HP_W-1:0]     w_hpANext;
  logic [HP_W-1:0]     w_hpBNext;

  // Only the active tank's button matters; the other one is never looked at.
  assign w_fireActive = r_tank ? bus.fire_b : bus.fire_a;

  // The charge is dropped when a shot is scored, and builds only while aiming/charging.
  assign w_meterClr = Reset || (r_state == RESOLVE);
  assign w_meterEn  = w_fireActive && !w_atMax && ((r_state == AIM) || (r_state == CHARGE));

  // A registered hit damages the opponent of whoever is shooting.
  assign w_hpANext = hpAfterHit(r_hpA, r_hit && r_tank);
  assign w_hpBNext = hpAfterHit(r_hpB, r_hit && !r_tank);

  charge_meter #(
    .STEP (CHARGE_STEP),
    .MAX  (CHARGE_MAX)
  ) u_chargeMeter (
    .clk    (frame_clk),
    .clr    (w_meterClr),
    .en     (w_meterEn),
    .value  (w_charge),
    .at_max (w_atMax)
  );

  // Turn FSM with registered outputs; shoot is a one-frame pulse raised on entry to FIRE.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      r_state    <= ARM;
      r_tank     <= 1'b0;
      r_shoot    <= 1'b0;
      r_hit      <= 1'b0;
      r_gameOver <= 1'b0;
      r_winner   <= 1'b0;
      r_hpA      <= HP_W'(HP_INIT);
      r_hpB      <= HP_W'(HP_INIT);
      r_flight   <= '0;
      r_settle   <= '0;
    end else begin
      r_shoot <= 1'b0;
      unique case (r_state)
        ARM: begin
          if (!w_fireActive) r_state <= AIM;
        end
        AIM: begin
          if (w_fireActive) r_state <= CHARGE;
        end
        CHARGE: begin
          if (!w_fireActive) begin
            r_state <= FIRE;
            r_shoot <= 1'b1;
          end
        end
        FIRE: begin
          r_state  <= FLIGHT;
          r_flight <= '0;
        end
        FLIGHT: begin
          r_flight <= r_flight + FLIGHT_W'(1);
          if (bus.bullet_hit) begin
            r_hit   <= 1'b1;
            r_state <= RESOLVE;
          end else if (bus.bullet_done || (r_flight == FLIGHT_LAST)) begin
            r_hit   <= 1'b0;
            r_state <= RESOLVE;
          end
        end
        RESOLVE: begin
          r_hpA <= w_hpANext;
          r_hpB <= w_hpBNext;
          r_hit <= 1'b0;
          if ((w_hpANext == '0) || (w_hpBNext == '0)) begin
            r_state    <= OVER;
            r_gameOver <= 1'b1;
            r_winner   <= r_tank;
          end else begin
            r_state  <= SETTLE;
            r_settle <= '0;
          end
        end
        SETTLE: begin
          if (r_settle == SETTLE_LAST) begin
            r_settle <= '0;
            r_tank   <= ~r_tank;
            r_state  <= ARM;
          end else begin
            r_settle <= r_settle + SETTLE_W'(1);
          end
        end
        OVER: begin
          r_state <= OVER;
        end
        default: begin
          r_state <= ARM;
        end
      endcase
    end
  end

  assign bus.currentTank = {1'b0, r_tank};
  assign bus.shoot       = r_shoot;
  assign bus.y_component = w_charge;
  assign bus.hp_a        = r_hpA;
  assign bus.hp_b        = r_hpB;
  assign bus.game_over   = r_gameOver;
  assign bus.winner      = r_winner;

endmodule

// File: tb/tb_turn_sequencer.sv
// Self-checking bench for turn_sequencer: a hand-derived vector table, a few
// directed multi-frame sequences, and a long random run, all shadowed every
// frame by a turn-level reference model.
module tb_turn_sequencer;
  import tank_game_pkg::*;

  localparam int HP0    = 5;
  localparam int STEP   = 10;
  localparam int CMAX   = 600;
  localparam int TMO    = 255;
  localparam int SETTLE = 30;

  logic frame_clk = 1'b0;
  logic Reset;

  turn_sequencer_if bus();

  turn_sequencer #(
    .HP_INIT        (HP0),
    .CHARGE_STEP    (STEP),
    .CHARGE_MAX     (CMAX),
    .FLIGHT_TIMEOUT (TMO),
    .SETTLE_FRAMES  (SETTLE)
  ) dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .bus       (bus)
  );

  // Free-running frame clock.
  always #5 frame_clk = ~frame_clk;

  typedef struct packed {
    logic [1:0] tank;
    logic       shoot;
    logic [9:0] y;
    logic [2:0] hpA;
    logic [2:0] hpB;
    logic       over;
    logic       win;
  } outs_t;

  typedef struct {
    logic  rst;
    logic  fa;
    logic  fb;
    logic  hit;
    logic  done;
    int    n;
    outs_t exp;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  // Turn-level reference model: what phase of a turn we are in, how many
  // frames the button has been held, how long the bullet has flown.
  typedef enum int {M_WAIT_RELEASE, M_WAIT_PRESS, M_HOLD, M_LAUNCH, M_FLY, M_SCORE, M_PAUSE, M_DONE} mphase_t;
  mphase_t mPhase;
  int  mTurn, mHeld, mFlown, mPaused;
  int  mHp[2];
  bit  mScored, mOver, mWin, mShoot;

  function automatic void modelStep(input logic rst, input logic fa, input logic fb,
                                    input logic hit, input logic done);
    bit act;
    int opp;
    if (rst) begin
      mPhase = M_WAIT_RELEASE; mTurn = 0; mHeld = 0; mFlown = 0; mPaused = 0;
      mHp[0] = HP0; mHp[1] = HP0; mScored = 0; mOver = 0; mWin = 0; mShoot = 0;
      return;
    end
    act = (mTurn == 0) ? fa : fb;
    mShoot = 0;
    case (mPhase)
      M_WAIT_RELEASE: if (!act) mPhase = M_WAIT_PRESS;
      M_WAIT_PRESS:   if (act) begin mHeld = 1; mPhase = M_HOLD; end
      M_HOLD:         if (act) mHeld++; else begin mPhase = M_LAUNCH; mShoot = 1; end
      M_LAUNCH:       begin mFlown = 0; mPhase = M_FLY; end
      M_FLY: begin
        mFlown++;
        if (hit)                      begin mScored = 1; mPhase = M_SCORE; end
        else if (done || mFlown == TMO) begin mScored = 0; mPhase = M_SCORE; end
      end
      M_SCORE: begin
        opp = 1 - mTurn;
        if (mScored && mHp[opp] > 0) mHp[opp]--;
        mHeld = 0;
        if (mHp[0] == 0 || mHp[1] == 0) begin mOver = 1; mWin = (mTurn == 1); mPhase = M_DONE; end
        else begin mPaused = 0; mPhase = M_PAUSE; end
      end
      M_PAUSE: begin
        mPaused++;
        if (mPaused == SETTLE) begin mTurn = 1 - mTurn; mPhase = M_WAIT_RELEASE; end
      end
      default: ;
    endcase
  endfunction

  function automatic outs_t modelOuts();
    outs_t o;
    int ch;
    ch = mHeld * STEP;
    if (ch > CMAX) ch = CMAX;
    o = {2'(mTurn), mShoot, 10'(ch), 3'(mHp[0]), 3'(mHp[1]), mOver, mWin};
    return o;
  endfunction

  function automatic string fmtOuts(input outs_t o);
    return $sformatf("tank=%0d shoot=%0d y=%0d hpA=%0d hpB=%0d over=%0d win=%0d",
                     o.tank, o.shoot, o.y, o.hpA, o.hpB, o.over, o.win);
  endfunction

  task automatic checkOutput(input string name, input outs_t exp);
    outs_t act;
    act = {bus.currentTank, bus.shoot, bus.y_component, bus.hp_a, bus.hp_b, bus.game_over, bus.winner};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s @%0t got {%s} expected {%s}", name, $time, fmtOuts(act), fmtOuts(exp));
    end
  endtask

  task automatic checkValue(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s @%0t got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // One frame: drive inputs, advance the model, check after the edge.
  task automatic applyStimulus(input logic rst, input logic fa, input logic fb,
                               input logic hit, input logic done);
    Reset           = rst;
    bus.fire_a      = fa;
    bus.fire_b      = fb;
    bus.bullet_hit  = hit;
    bus.bullet_done = done;
    modelStep(rst, fa, fb, hit, done);
    @(posedge frame_clk);
    @(negedge frame_clk);
    checkOutput("model", modelOuts());
  endtask

  function automatic void addVec(input logic rst, input logic fa, input logic fb,
                                 input logic hit, input logic done, input int n,
                                 input int tank, input int shoot, input int y,
                                 input int hpA, input int hpB, input int over, input int win);
    vec_t v;
    v.rst = rst; v.fa = fa; v.fb = fb; v.hit = hit; v.done = done; v.n = n;
    v.exp = {2'(tank), 1'(shoot), 10'(y), 3'(hpA), 3'(hpB), 1'(over), 1'(win)};
    vecs.push_back(v);
  endfunction

  // A full turn for one tank starting in ARM with buttons released.
  task automatic playTurn(input bit isB, input bit scoreHit);
    applyStimulus(0, 0, 0, 0, 0);
    repeat (2) applyStimulus(0, !isB, isB, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, scoreHit, !scoreHit);
    applyStimulus(0, 0, 0, 0, 0);
    if (!mOver) repeat (SETTLE) applyStimulus(0, 0, 0, 0, 0);
  endtask

  initial begin
    int shootSeen;
    logic fa, fb, hit, done, rst;

    Reset = 1'b1; bus.fire_a = 0; bus.fire_b = 0; bus.bullet_hit = 0; bus.bullet_done = 0;

    //          rst fa fb hit done  n   tank sh  y   hpA hpB ov win
    addVec(1, 0, 0, 0, 0,   1,  0, 0,   0, 5, 5, 0, 0);
    addVec(0, 0, 0, 0, 0,   1,  0, 0,   0, 5, 5, 0, 0);
    addVec(0, 1, 0, 0, 0,   5,  0, 0,  50, 5, 5, 0, 0);
    addVec(0, 0, 0, 0, 0,   1,  0, 1,  50, 5, 5, 0, 0);
    addVec(0, 0, 0, 0, 0,   1,  0, 0,  50, 5, 5, 0, 0);
    addVec(0, 0, 0, 1, 1,   1,  0, 0,  50, 5, 5, 0, 0);
    addVec(0, 0, 0, 0, 0,   1,  0, 0,   0, 5, 4, 0, 0);
    addVec(0, 0, 0, 0, 0,  29,  0, 0,   0, 5, 4, 0, 0);
    addVec(0, 0, 0, 0, 0,   1,  1, 0,   0, 5, 4, 0, 0);
    addVec(0, 1, 0, 0, 0,   1,  1, 0,   0, 5, 4, 0, 0);
    addVec(0, 1, 0, 0, 0,   3,  1, 0,   0, 5, 4, 0, 0);
    addVec(0, 0, 1, 0, 0,   3,  1, 0,  30, 5, 4, 0, 0);
    addVec(0, 0, 0, 0, 0,   1,  1, 1,  30, 5, 4, 0, 0);
    addVec(0, 0, 0, 0, 0,   1,  1, 0,  30, 5, 4, 0, 0);
    addVec(0, 0, 0, 0, 0, 254,  1, 0,  30, 5, 4, 0, 0);
    addVec(0, 0, 0, 0, 0,   1,  1, 0,  30, 5, 4, 0, 0);
    addVec(0, 0, 0, 0, 0,   1,  1, 0,   0, 5, 4, 0, 0);
    addVec(0, 0, 0, 0, 0,  30,  0, 0,   0, 5, 4, 0, 0);
    addVec(0, 1, 0, 0, 0,   3,  0, 0,   0, 5, 4, 0, 0);
    addVec(0, 0, 0, 0, 0,   1,  0, 0,   0, 5, 4, 0, 0);
    addVec(0, 1, 0, 0, 0, 100,  0, 0, 600, 5, 4, 0, 0);
    addVec(0, 1, 1, 0, 0,   1,  0, 0, 600, 5, 4, 0, 0);
    addVec(0, 1, 0, 0, 0,   1,  0, 0, 600, 5, 4, 0, 0);
    addVec(0, 0, 1, 0, 0,   1,  0, 1, 600, 5, 4, 0, 0);
    addVec(0, 0, 1, 0, 0,   1,  0, 0, 600, 5, 4, 0, 0);
    addVec(0, 0, 0, 0, 1,   1,  0, 0, 600, 5, 4, 0, 0);
    addVec(0, 0, 0, 0, 0,   1,  0, 0,   0, 5, 4, 0, 0);
    addVec(0, 0, 0, 1, 0,  30,  1, 0,   0, 5, 4, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      for (int k = 0; k < vecs[i].n; k++)
        applyStimulus(vecs[i].rst, vecs[i].fa, vecs[i].fb, vecs[i].hit, vecs[i].done);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Tank A wins with five hits while B always misses.
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      playTurn(0, 1);
      if (i < 4) playTurn(1, 0);
    end
    checkValue("gameover_hp_b", int'(bus.hp_b), 0);
    checkValue("gameover_hp_a", int'(bus.hp_a), HP0);
    checkValue("gameover_flag", int'(bus.game_over), 1);
    checkValue("gameover_winner", int'(bus.winner), 0);
    shootSeen = 0;
    for (int c = 0; c < 40; c++) begin
      applyStimulus(0, 1'($urandom_range(1)), 1'($urandom_range(1)),
                    1'($urandom_range(1)), 1'($urandom_range(1)));
      shootSeen += int'(bus.shoot);
    end
    checkValue("over_no_shoot", shootSeen, 0);

    // Reset in mid-flight while A keeps the button pressed.
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    repeat (2) applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    repeat (3) applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("midflight_reset", {2'd0, 1'b0, 10'd0, 3'd5, 3'd5, 1'b0, 1'b0});
    shootSeen = 0;
    for (int c = 0; c < 10; c++) begin
      applyStimulus(0, 1, 0, 0, 0);
      shootSeen += int'(bus.shoot);
    end
    checkValue("held_no_shoot", shootSeen, 0);
    checkValue("held_no_charge", int'(bus.y_component), 0);
    applyStimulus(0, 0, 0, 0, 0);
    repeat (2) applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkValue("repress_shoot", int'(bus.shoot), 1);
    checkValue("repress_charge", int'(bus.y_component), 2 * STEP);

    // Long random run against the model.
    fa = 0; fb = 0;
    applyStimulus(1, 0, 0, 0, 0);
    for (int c = 0; c < 8000; c++) begin
      if ($urandom_range(5) == 0) fa = ~fa;
      if ($urandom_range(5) == 0) fb = ~fb;
      hit  = ($urandom_range(29) == 0);
      done = ($urandom_range(39) == 0);
      rst  = ($urandom_range(599) == 0);
      applyStimulus(rst, fa, fb, hit, done);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/turn_sequencer.md
TURN_SEQUENCER -- requirements
Module: turn_sequencer

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- HP_INIT, 5, starting hit points per tank
- CHARGE_STEP, 10, charge increment per frame while fire held
- CHARGE_MAX, 600, charge saturation value
- FLIGHT_TIMEOUT, 255, max frames in flight before forced turn end
- SETTLE_FRAMES, 30, pause frames between turns
REQ-002 Ports (name, direction, width, meaning), one per line:
- frame_clk, in, 1, frame-rate clock; single clock domain
- Reset, in, 1, synchronous, active-high
- fire_a, in, 1, tank A fire button, level
- fire_b, in, 1, tank B fire button, level
- bullet_hit, in, 1, one-frame pulse: bullet struck the enemy tank
- bullet_done, in, 1, one-frame pulse: bullet left the field or struck terrain without a hit
- currentTank, out, 2, active tank: 0 = A, 1 = B; bit 1 always 0
- shoot, out, 1, one-frame launch pulse to the bullet datapath
- y_component, out, 10, launch charge, unsigned
- hp_a, out, 3, tank A hit points
- hp_b, out, 3, tank B hit points
- game_over, out, 1, high once either hp reaches 0
- winner, out, 1, 0 = A won, 1 = B won; valid while game_over is high

Function
REQ-003 The block SHALL be an FSM with states ARM, AIM, CHARGE, FIRE, FLIGHT, RESOLVE, SETTLE, OVER; all state changes occur on the frame_clk rising edge.
REQ-004 The active fire signal SHALL be fire_a when currentTank = 0 and fire_b otherwise; the inactive player's fire SHALL be ignored in every state.
REQ-005 ARM: go to AIM on the first frame the active fire is low, so a button held over from the previous turn cannot fire.
REQ-006 AIM: y_component = 0; go to CHARGE on the first frame the active fire is high.
REQ-007 CHARGE: y_component SHALL increase by CHARGE_STEP each frame the active fire stays high and saturate at CHARGE_MAX, never wrapping; on the first frame fire is low, go to FIRE with y_component held.
REQ-008 FIRE: shoot SHALL be high for exactly this one frame, then the FSM goes to FLIGHT and clears the flight counter; y_component holds until RESOLVE.
REQ-009 FLIGHT: the flight counter SHALL increment each frame; exit to RESOLVE on bullet_hit, on bullet_done, or when the counter reaches FLIGHT_TIMEOUT, whichever comes first.
REQ-010 If bullet_hit and bullet_done are high in the same frame, bullet_hit SHALL take priority.
REQ-011 bullet_hit and bullet_done SHALL be ignored in every state except FLIGHT.
REQ-012 RESOLVE (one frame): on a registered hit, decrement the opponent's hp, saturating at 0; set y_component = 0.
REQ-013 After RESOLVE: if either hp is 0, go to OVER with game_over = 1 and winner = currentTank[0]; otherwise go to SETTLE.
REQ-014 SETTLE: count SETTLE_FRAMES frames, then toggle currentTank[0] and go to ARM.
REQ-015 OVER SHALL be terminal until Reset: shoot = 0, and fire inputs and bullet pulses are ignored.
REQ-016 shoot SHALL be high only in FIRE, and at most once per turn.
REQ-017 All outputs SHALL be registered; y_component arithmetic is unsigned 10-bit with a saturation compare performed before the add.

Reset
REQ-018 On Reset high at a frame_clk edge, in any state including mid-flight:
- state = ARM, currentTank = 0, shoot = 0, y_component = 0
- hp_a = hp_b = HP_INIT, game_over = 0, winner = 0
- flight and settle counters = 0
REQ-019 Reset SHALL override every input in the same frame.

Structure
REQ-020 The state enum and the HP_INIT, CHARGE_STEP, CHARGE_MAX, FLIGHT_TIMEOUT and SETTLE_FRAMES defaults SHALL live in the shared package tank_game_pkg.
REQ-021 The saturating charge accumulator SHALL be the sub-module charge_meter, with inputs clr, en and outputs value, at_max.

Verification
REQ-022 Reset, then fire_a held 5 frames and released -> y_component = 50, shoot pulses exactly 1 frame, currentTank = 0.
REQ-023 fire_a held 100 frames -> y_component saturates at 600 with no wrap; fire_b pulses during A's turn produce no shoot.
REQ-024 In FLIGHT, bullet_hit and bullet_done pulse in the same frame -> hp_b goes 5 -> 4; after 30 settle frames currentTank = 1.
REQ-025 No bullet pulses after FIRE -> RESOLVE after 255 flight frames, hp unchanged, turn passes to B.
REQ-026 Five hits by A -> hp_b = 0, game_over = 1, winner = 0; further fire_a and fire_b produce no shoot.
REQ-027 Reset asserted mid-FLIGHT with fire_a held -> all outputs return to reset values; no shoot until fire_a is released and pressed again.
